// File: rtl/fsk_tx_scheduler.sv
// Two-source round-robin frame scheduler for the FSK DDS: each granted 32-bit word becomes
// start(space) + 32 data bits LSB-first + stop(mark), optionally followed by mark gap symbols.
module fsk_tx_scheduler #(
    parameter int CFG_W = 32,
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] symbol_dur,
    input  logic [CFG_W-1:0] mark_frq,
    input  logic [CFG_W-1:0] space_frq,
    input  logic [GAP_W-1:0] gap_symbols,
    input  logic             s0_valid,
    input  logic [31:0]      s0_data,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [31:0]      s1_data,
    output logic             s1_ready,
    output logic [CFG_W-1:0] freq_out,
    output logic             sym_strobe,
    output logic             busy,
    output logic             tx_src
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [CFG_W-1:0] CFG_ONE = {{(CFG_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic [CFG_W-1:0] dur_q, dur_d;
    logic [CFG_W-1:0] mark_q, mark_d;
    logic [CFG_W-1:0] space_q, space_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CFG_W-1:0] tick_q, tick_d;
    logic [4:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             pref_q, pref_d;
    logic             src_q, src_d;
    logic             busy_q, busy_d;
    logic [CFG_W-1:0] freq_q, freq_d;
    logic             strobe_q, strobe_d;

    logic             grant_s;
    logic             accept_s;
    logic             sym_end_s;
    logic             first_tick_s;

    // pref_q holds the source favoured on a tie; it starts at s0 and flips past each winner
    always_comb begin
        grant_s = 1'b0;
        if (s0_valid && s1_valid) begin
            grant_s = pref_q;
        end else if (s1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        s0_ready = (state_q == ST_IDLE) && !rst && s0_valid && (grant_s == 1'b0);
        s1_ready = (state_q == ST_IDLE) && !rst && s1_valid && (grant_s == 1'b1);
        accept_s = s0_ready || s1_ready;
    end

    assign sym_end_s    = (tick_q == (dur_q - CFG_ONE));
    assign first_tick_s = (tick_q == {CFG_W{1'b0}});

    // Frame sequencing, config latching and next output values
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        dur_d    = dur_q;
        mark_d   = mark_q;
        space_d  = space_q;
        gap_d    = gap_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        gcnt_d   = gcnt_q;
        pref_d   = pref_q;
        src_d    = src_q;
        busy_d   = busy_q;
        freq_d   = freq_q;
        strobe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                freq_d = mark_frq;
                if (accept_s) begin
                    state_d = ST_START;
                    word_d  = grant_s ? s1_data : s0_data;
                    dur_d   = (symbol_dur == {CFG_W{1'b0}}) ? CFG_ONE : symbol_dur;
                    mark_d  = mark_frq;
                    space_d = space_frq;
                    gap_d   = gap_symbols;
                    tick_d  = {CFG_W{1'b0}};
                    bit_d   = 5'd0;
                    gcnt_d  = {GAP_W{1'b0}};
                    pref_d  = !grant_s;
                    src_d   = grant_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                freq_d   = space_q;
                strobe_d = first_tick_s;
                if (sym_end_s) begin
                    tick_d  = {CFG_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    tick_d = tick_q + CFG_ONE;
                end
            end
            ST_DATA: begin
                freq_d   = word_q[bit_q] ? mark_q : space_q;
                strobe_d = first_tick_s;
                if (sym_end_s) begin
                    tick_d = {CFG_W{1'b0}};
                    if (bit_q == 5'd31) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    tick_d = tick_q + CFG_ONE;
                end
            end
            ST_STOP: begin
                freq_d   = mark_q;
                strobe_d = first_tick_s;
                if (sym_end_s) begin
                    tick_d = {CFG_W{1'b0}};
                    if (gap_q != {GAP_W{1'b0}}) begin
                        state_d = ST_GAP;
                        gcnt_d  = {GAP_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    tick_d = tick_q + CFG_ONE;
                end
            end
            ST_GAP: begin
                freq_d   = mark_q;
                strobe_d = first_tick_s;
                if (sym_end_s) begin
                    tick_d = {CFG_W{1'b0}};
                    if (gcnt_q == (gap_q - GAP_ONE)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gcnt_d = gcnt_q + GAP_ONE;
                    end
                end else begin
                    tick_d = tick_q + CFG_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            word_q   <= 32'd0;
            dur_q    <= {CFG_W{1'b0}};
            mark_q   <= {CFG_W{1'b0}};
            space_q  <= {CFG_W{1'b0}};
            gap_q    <= {GAP_W{1'b0}};
            tick_q   <= {CFG_W{1'b0}};
            bit_q    <= 5'd0;
            gcnt_q   <= {GAP_W{1'b0}};
            pref_q   <= 1'b0;
            src_q    <= 1'b0;
            busy_q   <= 1'b0;
            freq_q   <= {CFG_W{1'b0}};
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            dur_q    <= dur_d;
            mark_q   <= mark_d;
            space_q  <= space_d;
            gap_q    <= gap_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            gcnt_q   <= gcnt_d;
            pref_q   <= pref_d;
            src_q    <= src_d;
            busy_q   <= busy_d;
            freq_q   <= freq_d;
            strobe_q <= strobe_d;
        end
    end

    assign freq_out   = freq_q;
    assign sym_strobe = strobe_q;
    assign busy       = busy_q;
    assign tx_src     = src_q;

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Bench for fsk_tx_scheduler: per-clock comparison against a frame-index reference model,
// a table of single-frame configurations, hand sequences for arbitration/reset, and random traffic.
module tb_fsk_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] symbol_dur, mark_frq, space_frq;
    logic [15:0] gap_symbols;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic [31:0] freq_out;
    logic        sym_strobe, busy, tx_src;

    always #5 clk = ~clk;

    fsk_tx_scheduler #(.CFG_W(32), .GAP_W(16)) dut (
        .clk(clk), .rst(rst), .symbol_dur(symbol_dur), .mark_frq(mark_frq),
        .space_frq(space_frq), .gap_symbols(gap_symbols),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .freq_out(freq_out), .sym_strobe(sym_strobe), .busy(busy), .tx_src(tx_src)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a frame is a flat list of (34+G)*D clocks indexed by m_i
    bit          m_active;
    int          m_i, m_len, m_d, m_g;
    logic [31:0] m_word, m_mark, m_space, m_freq;
    bit          m_pref, m_src, m_busy, m_strobe;
    bit          acc0_f, acc1_f;

    typedef struct {
        logic [31:0] dur;
        logic [15:0] gap;
        logic [31:0] word;
        int          exp_busy;
        int          exp_strobes;
        int          exp_space;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] entry_freq(input int i);
        int sym;
        sym = i / m_d;
        if (sym == 0) return m_space;
        if (sym <= 32) return m_word[sym-1] ? m_mark : m_space;
        return m_mark;
    endfunction

    task automatic step();
        bit g, e_r0, e_r1;
        #1;
        if (s0_valid && s1_valid) g = m_pref;
        else g = s1_valid;
        e_r0 = !rst && !m_active && s0_valid && !g;
        e_r1 = !rst && !m_active && s1_valid && g;
        chk("s0_ready", 32'(s0_ready), 32'(e_r0));
        chk("s1_ready", 32'(s1_ready), 32'(e_r1));
        acc0_f = s0_valid && s0_ready;
        acc1_f = s1_valid && s1_ready;
        if (rst) begin
            m_active = 0; m_busy = 0; m_src = 0; m_pref = 0;
            m_freq = 32'd0; m_strobe = 0;
        end else if (!m_active) begin
            m_freq = mark_frq; m_strobe = 0;
            if (e_r0 || e_r1) begin
                m_word  = e_r1 ? s1_data : s0_data;
                m_d     = (symbol_dur == 32'd0) ? 1 : int'(symbol_dur);
                m_g     = int'(gap_symbols);
                m_mark  = mark_frq;
                m_space = space_frq;
                m_len   = (34 + m_g) * m_d;
                m_i     = 0;
                m_active = 1; m_busy = 1;
                m_src   = e_r1;
                m_pref  = !e_r1;
            end
        end else begin
            m_freq   = entry_freq(m_i);
            m_strobe = ((m_i % m_d) == 0);
            m_i++;
            if (m_i == m_len) begin
                m_active = 0; m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("freq_out", freq_out, m_freq);
        chk("sym_strobe", 32'(sym_strobe), 32'(m_strobe));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_src", 32'(tx_src), 32'(m_src));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Presents a word on s0 until accepted (bounded), then drops valid
    task automatic send_s0(input logic [31:0] w);
        bit got;
        got = 0;
        s0_valid = 1'b1;
        s0_data  = w;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = acc0_f;
        end
        s0_valid = 1'b0;
        chk("s0_accept", 32'(got), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && busy; n++) step();
        step();
    endtask

    initial begin
        int busy_cnt, strobe_cnt, space_cnt, idle_cnt, naccept;
        int order[$];

        rst = 1'b1;
        symbol_dur = 32'd4; mark_frq = 32'h100; space_frq = 32'h200; gap_symbols = 16'd0;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 32'd0; s1_data = 32'd0;
        m_active = 0; m_pref = 0; m_src = 0; m_busy = 0; m_d = 1;
        do_reset();
        chk("reset_freq", freq_out, 32'd0);

        tbl[0] = '{32'd4, 16'd0, 32'h0000_0001, 136, 34, 128};
        tbl[1] = '{32'd0, 16'd0, 32'hFFFF_FFFF,  34, 34,   1};
        tbl[2] = '{32'd5, 16'd3, 32'hA5A5_A5A5, 185, 37,  85};
        tbl[3] = '{32'd2, 16'd0, 32'h5A5A_5A5A,  68, 34,  34};
        tbl[4] = '{32'd1, 16'd2, 32'h0000_0000,  36, 36,  33};

        for (int t = 0; t < 5; t++) begin
            symbol_dur = tbl[t].dur; gap_symbols = tbl[t].gap;
            mark_frq = 32'h100; space_frq = 32'h200;
            send_s0(tbl[t].word);
            busy_cnt = 0; strobe_cnt = 0; space_cnt = 0;
            if (busy) busy_cnt++;
            for (int n = 0; n < 400; n++) begin
                step();
                if (busy) busy_cnt++;
                if (sym_strobe) strobe_cnt++;
                if (freq_out == 32'h200) space_cnt++;
                if (!busy) break;
            end
            step();
            chk($sformatf("tbl%0d_busy_clks", t), 32'(busy_cnt), 32'(tbl[t].exp_busy));
            chk($sformatf("tbl%0d_strobes", t), 32'(strobe_cnt), 32'(tbl[t].exp_strobes));
            chk($sformatf("tbl%0d_space_clks", t), 32'(space_cnt), 32'(tbl[t].exp_space));
            chk($sformatf("tbl%0d_idle_mark", t), freq_out, 32'h100);
        end

        // Round-robin with both sources continuously valid
        do_reset();
        symbol_dur = 32'd2; gap_symbols = 16'd0;
        s0_valid = 1'b1; s1_valid = 1'b1;
        s0_data = 32'hA5A5_A5A5; s1_data = 32'h5A5A_5A5A;
        naccept = 0; idle_cnt = 0;
        for (int n = 0; n < 400 && naccept < 4; n++) begin
            step();
            if (acc0_f) order.push_back(0);
            if (acc1_f) order.push_back(1);
            if (acc0_f || acc1_f) naccept++;
            else if (naccept > 0 && !busy) idle_cnt++;
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
        chk("rr_idle_clks", 32'(idle_cnt), 32'd3);
        drain(200);

        // Config changes mid-frame are ignored; IDLE follows the new mark
        symbol_dur = 32'd3; gap_symbols = 16'd1; mark_frq = 32'h100; space_frq = 32'h200;
        send_s0(32'h1234_5678);
        for (int n = 0; n < 20; n++) step();
        mark_frq = 32'h300; symbol_dur = 32'd7; space_frq = 32'h444; gap_symbols = 16'd5;
        busy_cnt = 21;
        for (int n = 0; n < 300 && busy; n++) begin
            step();
            if (busy) busy_cnt++;
        end
        chk("midcfg_busy_clks", 32'(busy_cnt), 32'd105);
        step();
        chk("midcfg_idle_mark", freq_out, 32'h300);

        // Reset in bit 10 with s1 pending
        do_reset();
        symbol_dur = 32'd2; gap_symbols = 16'd0; mark_frq = 32'h100; space_frq = 32'h200;
        send_s0(32'hCAFE_F00D);
        for (int n = 0; n < 22; n++) step();
        s1_valid = 1'b1; s1_data = 32'h0F0F_0F0F; rst = 1'b1;
        step();
        chk("rst_s1_blocked", 32'(acc1_f), 32'd0);
        chk("rst_freq", freq_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_s1_accept", 32'(acc1_f), 32'd1);
        s1_valid = 1'b0;
        drain(200);

        // Random traffic with random config, occasional reset
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) begin
                symbol_dur  = 32'($urandom_range(0, 3));
                gap_symbols = 16'($urandom_range(0, 2));
                mark_frq    = $urandom;
                space_frq   = $urandom;
            end
            if (!s0_valid || acc0_f) begin
                s0_valid = ($urandom_range(0, 3) == 0);
                s0_data  = $urandom;
            end
            if (!s1_valid || acc1_f) begin
                s1_valid = ($urandom_range(0, 3) == 0);
                s1_data  = $urandom;
            end
            step();
        end
        rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
